multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle sequencer for the RV32I core datapath: replaces single-cycle decode with an FSM that steps each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK.
- Shares one unified memory port between instruction fetch and data access, stalling on a ready handshake.
- Drives the existing datapath strobes and the ALU class code; counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter (wraps modulo 2^CNT_W).

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- instr  in  32  memory read data; opcode field instr[6:2] sampled when ir_write=1
- mem_ready  in  1  memory handshake: access in FETCH/MEM completes in a cycle where mem_ready=1
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero (branch)
- ir_write  out  1  latch instruction register
- iord  out  1  memory address select: 0=PC, 1=ALU result
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_to_reg  out  1  writeback select: 1=memory data, 0=ALU/link
- reg_write  out  1  register file write enable
- alu_src  out  1  ALU B select: 1=immediate, 0=rs2
- alu_op  out  2  00 add, 01 branch compare, 10 funct decode
- jump  out  1  PC source = jump target; rd gets PC+4
- state_o  out  3  current state: 0 FETCH, 1 DECODE, 2 EXECUTE, 3 MEM, 4 WRITEBACK, 7 HALT
- retired_cnt  out  CNT_W  instructions completed since reset
- illegal  out  1  one-cycle pulse on unrecognised opcode

Behaviour:
- Reset (rst=1 at edge): state<=FETCH, opc_q<=0, retired_cnt<=0. While rst=1, all strobe outputs forced 0. First cycle after release is FETCH.
- Outputs are a Moore decode of state and opc_q. Exceptions: pc_write and ir_write in FETCH are also qualified by mem_ready. All strobes not listed for a state are 0.
- FETCH: mem_read=1, iord=0. Hold while mem_ready=0. When mem_ready=1: ir_write=1, pc_write=1, alu_op=00 (PC+4), opc_q<=instr[6:2], go to DECODE.
- DECODE: no strobes. Classify opc_q and go to EXECUTE; an illegal opcode takes the path given under Optional Feature.
- Opcode classes: 01100 R; 00000 LOAD; 01000 STORE; 11000 BRANCH; 00100 OPIMM; 11011 JAL; 11001 JALR; 01101 LUI; 00101 AUIPC. Anything else is illegal.
- EXECUTE, per class:
  - R: alu_src=0, alu_op=10.
  - OPIMM: alu_src=1, alu_op=10.
  - LOAD/STORE: alu_src=1, alu_op=00.
  - BRANCH: alu_src=0, alu_op=01, pc_write_cond=1.
  - JAL/JALR: jump=1, pc_write=1, alu_src=1, alu_op=00.
  - LUI/AUIPC: alu_src=1, alu_op=00.
- Next state after EXECUTE: LOAD/STORE to MEM; BRANCH to FETCH (retires); all others to WRITEBACK.
- MEM: iord=1; mem_read=1 for LOAD, mem_write=1 for STORE. Both strobes stay held while mem_ready=0.
  - On mem_ready=1: LOAD goes to WRITEBACK; STORE goes to FETCH (retires).
- WRITEBACK: reg_write=1; mem_to_reg=1 for LOAD, else 0; jump=1 for JAL/JALR (link select). Go to FETCH (retires).
- Retirement: retired_cnt increments by 1 on the edge leaving the final state of an instruction. Wraps from all-ones to 0.
- Latency with mem_ready tied high:
  - BRANCH: 3 cycles.
  - R, OPIMM, STORE, JAL, JALR, LUI, AUIPC: 4 cycles.
  - LOAD: 5 cycles.
  - Each wait cycle adds 1.
- mem_ready outside FETCH/MEM is ignored.
- rst asserted mid-instruction: abort at that edge, return to FETCH, no retirement counted, no strobe asserted in the reset cycle.
- state_o encodings 5 and 6 are unreachable. If reached, go to FETCH next cycle with all strobes 0.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: illegal opcode in DECODE raises illegal for one cycle and enters HALT (state_o=7).
  - HALT holds all strobes 0 and ignores mem_ready; only rst exits.
  - retired_cnt is not incremented.
- Undefined: illegal opcode raises illegal for one cycle, returns DECODE to FETCH, and counts as retired (NOP). HALT is never entered.

Test Plan:
- Reset: rst=1 for 2 cycles then 0, mem_ready=1 -> during reset all strobes 0, retired_cnt=0; next cycle state_o=0, mem_read=1, iord=0.
- R-type add (instr=0x003100B3), mem_ready=1 -> states 0,1,2,4,0 over 4 cycles; reg_write=1 only in WRITEBACK with mem_to_reg=0; alu_op=10 in EXECUTE; retired_cnt 0 to 1.
- Load lw (0x0000A103), mem_ready low 2 cycles in MEM -> mem_read and iord held 3 cycles in MEM; then WRITEBACK with mem_to_reg=1, reg_write=1; total 7 cycles.
- Branch beq (0x00208463) -> EXECUTE asserts pc_write_cond=1, alu_op=01, returns to FETCH after 3 cycles; no reg_write at any point.
- Illegal opcode (0x0000007F):
  - with ILLEGAL_TRAP_EN: illegal pulses once, state_o=7 held for 10 cycles, retired_cnt unchanged.
  - without it: illegal pulses once, back to FETCH, retired_cnt +1.
- Store sw (0x0020A023) with rst asserted during MEM -> mem_write drops in reset cycle, state_o=0 after, retired_cnt unchanged; CNT_W=4 run of 16 instructions -> counter wraps to 0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control sequencer.
// Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK over a
// shared memory port, drives the datapath strobes and counts retired
// instructions.
// Optional build macro ILLEGAL_TRAP_EN: an illegal opcode parks the
// sequencer in HALT until reset, instead of retiring it as a NOP.
//
// state | meaning
// ------+-------------------------------------------------------------
// 0     | FETCH     read instruction at PC, PC+4, latch IR on mem_ready
// 1     | DECODE    classify opcode, flag illegal
// 2     | EXECUTE   ALU operation / branch compare / jump
// 3     | MEM       data access at ALU address, wait for mem_ready
// 4     | WRITEBACK register file write (ALU, memory or link)
// 7     | HALT      trapped on illegal opcode (ILLEGAL_TRAP_EN only)
// 5,6   | unused    recover to FETCH with all strobes low

module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             ir_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             jump,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             illegal
);

  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXECUTE = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB = 3'd4;
  localparam logic [2:0] S_HALT = 3'd7;

  localparam logic [4:0] OP_R = 5'b01100;
  localparam logic [4:0] OP_LOAD = 5'b00000;
  localparam logic [4:0] OP_STORE = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_OPIMM = 5'b00100;
  localparam logic [4:0] OP_JAL = 5'b11011;
  localparam logic [4:0] OP_JALR = 5'b11001;
  localparam logic [4:0] OP_LUI = 5'b01101;
  localparam logic [4:0] OP_AUIPC = 5'b00101;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_BR = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [4:0] opc_q;
  logic       retire;

  logic is_r, is_load, is_store, is_branch, is_opimm;
  logic is_jal, is_jalr, is_lui, is_auipc, is_legal;

  // Only the opcode field of the instruction word matters to the sequencer.
  logic unused_instr;
  assign unused_instr = ^{instr[31:7], instr[1:0]};

  // Opcode class decode of the latched opcode.
  always_comb begin
    is_r      = (opc_q == OP_R);
    is_load   = (opc_q == OP_LOAD);
    is_store  = (opc_q == OP_STORE);
    is_branch = (opc_q == OP_BRANCH);
    is_opimm  = (opc_q == OP_OPIMM);
    is_jal    = (opc_q == OP_JAL);
    is_jalr   = (opc_q == OP_JALR);
    is_lui    = (opc_q == OP_LUI);
    is_auipc  = (opc_q == OP_AUIPC);
    is_legal  = is_r | is_load | is_store | is_branch | is_opimm |
                is_jal | is_jalr | is_lui | is_auipc;
  end

  // Next-state selection and retirement detection.
  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    case (state)
      S_FETCH: begin
        if (mem_ready) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (is_legal) begin
          state_nxt = S_EXECUTE;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          state_nxt = S_HALT;
`else
          state_nxt = S_FETCH;
          retire    = 1'b1;
`endif
        end
      end
      S_EXECUTE: begin
        if (is_load || is_store) begin
          state_nxt = S_MEM;
        end else if (is_branch) begin
          state_nxt = S_FETCH;
          retire    = 1'b1;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          if (is_load) begin
            state_nxt = S_WB;
          end else begin
            state_nxt = S_FETCH;
            retire    = 1'b1;
          end
        end
      end
      S_WB: begin
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
`ifdef ILLEGAL_TRAP_EN
      S_HALT: begin
        state_nxt = S_HALT;
      end
`endif
      default: begin
        state_nxt = S_FETCH;
      end
    endcase
  end

  // State, latched opcode and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FETCH;
      opc_q       <= 5'd0;
      retired_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH && mem_ready) opc_q <= instr[6:2];
      if (retire) retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end

  // Moore strobe decode; FETCH loads PC/IR only once the read completes.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src       = 1'b0;
    alu_op        = ALU_ADD;
    jump          = 1'b0;
    illegal       = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_DECODE: begin
        illegal = ~is_legal;
      end
      S_EXECUTE: begin
        if (is_r) begin
          alu_op = ALU_FUNCT;
        end else if (is_opimm) begin
          alu_src = 1'b1;
          alu_op  = ALU_FUNCT;
        end else if (is_branch) begin
          alu_op        = ALU_BR;
          pc_write_cond = 1'b1;
        end else if (is_jal || is_jalr) begin
          jump     = 1'b1;
          pc_write = 1'b1;
          alu_src  = 1'b1;
        end else begin
          alu_src = 1'b1;
        end
      end
      S_MEM: begin
        iord      = 1'b1;
        mem_read  = is_load;
        mem_write = is_store;
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_load;
        jump       = is_jal | is_jalr;
      end
      default: begin
      end
    endcase
    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      alu_src       = 1'b0;
      alu_op        = ALU_ADD;
      jump          = 1'b0;
      illegal       = 1'b0;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction cycle traces built from the
// class latency rules, compared cycle by cycle against the DUT.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'd0;
  logic        mem_ready = 1'b0;

  logic        pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write;
  logic        mem_to_reg, reg_write, alu_src, jump, illegal;
  logic [1:0]  alu_op;
  logic [2:0]  state_o;
  logic [31:0] retired_cnt;

  logic        b_pc_write, b_pc_write_cond, b_ir_write, b_iord, b_mem_read;
  logic        b_mem_write, b_mem_to_reg, b_reg_write, b_alu_src, b_jump;
  logic        b_illegal;
  logic [1:0]  b_alu_op;
  logic [2:0]  b_state_o;
  logic [3:0]  b_retired_cnt;

  multicycle_control #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src(alu_src),
    .alu_op(alu_op), .jump(jump), .state_o(state_o),
    .retired_cnt(retired_cnt), .illegal(illegal)
  );

  multicycle_control #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready),
    .pc_write(b_pc_write), .pc_write_cond(b_pc_write_cond),
    .ir_write(b_ir_write), .iord(b_iord), .mem_read(b_mem_read),
    .mem_write(b_mem_write), .mem_to_reg(b_mem_to_reg),
    .reg_write(b_reg_write), .alu_src(b_alu_src), .alu_op(b_alu_op),
    .jump(b_jump), .state_o(b_state_o), .retired_cnt(b_retired_cnt),
    .illegal(b_illegal)
  );

  always #5 clk = ~clk;

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam int C_R = 0, C_LOAD = 1, C_STORE = 2, C_BRANCH = 3, C_OPIMM = 4;
  localparam int C_JAL = 5, C_JALR = 6, C_LUI = 7, C_AUIPC = 8, C_ILL = 9;

  int n_tests = 0;
  int n_fail = 0;
  int unsigned model_cnt = 0;

  int         tr_st [64];
  logic       tr_rdy[64];
  int         ntr;
  logic [2:0] exp_st[64];
  logic [2:0] obs_st[64];
  logic [12:0] exp_sb[64];
  logic [12:0] obs_sb[64];

  wire [12:0] strb = {pc_write, pc_write_cond, ir_write, iord, mem_read,
                      mem_write, mem_to_reg, reg_write, alu_src, alu_op,
                      jump, illegal};

  logic [4:0] legal_ops[9] = '{5'b01100, 5'b00000, 5'b01000, 5'b11000,
                               5'b00100, 5'b11011, 5'b11001, 5'b01101,
                               5'b00101};

  function automatic int classify(input logic [4:0] op);
    case (op)
      5'b01100: return C_R;
      5'b00000: return C_LOAD;
      5'b01000: return C_STORE;
      5'b11000: return C_BRANCH;
      5'b00100: return C_OPIMM;
      5'b11011: return C_JAL;
      5'b11001: return C_JALR;
      5'b01101: return C_LUI;
      5'b00101: return C_AUIPC;
      default:  return C_ILL;
    endcase
  endfunction

  // Strobe table per state and class, bit order as in 'strb'.
  function automatic logic [12:0] strobes(input int st, input int cls, input logic rdy);
    logic pw, pwc, irw, io, mr, mw, m2r, rw, as, jp, il;
    logic [1:0] op;
    {pw, pwc, irw, io, mr, mw, m2r, rw, as, jp, il} = '0;
    op = 2'b00;
    case (st)
      0: begin mr = 1; irw = rdy; pw = rdy; end
      1: il = (cls == C_ILL);
      2: case (cls)
           C_R:      op = 2'b10;
           C_OPIMM:  begin as = 1; op = 2'b10; end
           C_BRANCH: begin op = 2'b01; pwc = 1; end
           C_JAL, C_JALR: begin jp = 1; pw = 1; as = 1; end
           default:  as = 1;
         endcase
      3: begin io = 1; mr = (cls == C_LOAD); mw = (cls == C_STORE); end
      4: begin rw = 1; m2r = (cls == C_LOAD); jp = (cls == C_JAL || cls == C_JALR); end
      default: ;
    endcase
    return {pw, pwc, irw, io, mr, mw, m2r, rw, as, op, jp, il};
  endfunction

  function automatic logic [31:0] rand_legal();
    logic [31:0] w;
    w = $urandom;
    return {w[31:7], legal_ops[$urandom_range(0, 8)], 2'b11};
  endfunction

  // Drives one instruction; records expected and observed per-cycle values.
  task automatic run_instr(input logic [31:0] ins, input int fwait,
                           input int mwait, input int abort_at);
    int cls;
    int n;
    cls = classify(ins[6:2]);
    n = 0;
    for (int k = 0; k < fwait; k++) begin tr_st[n] = 0; tr_rdy[n] = 0; n++; end
    tr_st[n] = 0; tr_rdy[n] = 1; n++;
    tr_st[n] = 1; tr_rdy[n] = 1'($urandom_range(0, 1)); n++;
    if (cls != C_ILL) begin
      tr_st[n] = 2; tr_rdy[n] = 1'($urandom_range(0, 1)); n++;
      if (cls == C_LOAD || cls == C_STORE) begin
        for (int k = 0; k < mwait; k++) begin tr_st[n] = 3; tr_rdy[n] = 0; n++; end
        tr_st[n] = 3; tr_rdy[n] = 1; n++;
      end
      if (cls != C_BRANCH && cls != C_STORE) begin
        tr_st[n] = 4; tr_rdy[n] = 1'($urandom_range(0, 1)); n++;
      end
    end
    ntr = n;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = (i == abort_at);
      mem_ready = tr_rdy[i];
      instr = (tr_st[i] == 0 && tr_rdy[i]) ? ins : $urandom;
      #1;
      exp_st[i] = 3'(tr_st[i]);
      exp_sb[i] = (i == abort_at) ? 13'd0 : strobes(tr_st[i], cls, tr_rdy[i]);
      obs_st[i] = state_o;
      obs_sb[i] = strb;
      if (i == abort_at) begin
        ntr = i + 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (abort_at >= 0) model_cnt = 0;
    else if (!(cls == C_ILL && TRAP)) model_cnt++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_cnt = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    n_tests++;
    if (strb !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_strobes got=%b want=%b", strb, 13'd0);
    end
    n_tests++;
    if (retired_cnt !== 32'd0 || b_retired_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_cnt got=%0d/%0d want=0", retired_cnt, b_retired_cnt);
    end
    rst = 1'b0;
    mem_ready = 1'b0;
    #1;
    n_tests++;
    if (state_o !== 3'd0 || strb !== strobes(0, C_R, 1'b0)) begin
      n_fail++;
      $display("FAIL reset_release got state=%0d strobes=%b want state=0 strobes=%b",
               state_o, strb, strobes(0, C_R, 1'b0));
    end
    @(posedge clk);
    #1;
    model_cnt = 0;
  endtask

  task automatic test_r_add();
    run_instr(32'h003100B3, 0, 0, -1);
    for (int i = 0; i < ntr; i++) begin
      n_tests++;
      if (obs_st[i] !== exp_st[i] || obs_sb[i] !== exp_sb[i]) begin
        n_fail++;
        $display("FAIL r_add cyc%0d got state=%0d strobes=%b want state=%0d strobes=%b",
                 i, obs_st[i], obs_sb[i], exp_st[i], exp_sb[i]);
      end
    end
    n_tests++;
    if (retired_cnt !== model_cnt || state_o !== 3'd0) begin
      n_fail++;
      $display("FAIL r_add_retire got cnt=%0d state=%0d want cnt=%0d state=0",
               retired_cnt, state_o, model_cnt);
    end
  endtask

  task automatic test_load();
    run_instr(32'h0000A103, 0, 2, -1);
    for (int i = 0; i < ntr; i++) begin
      n_tests++;
      if (obs_st[i] !== exp_st[i] || obs_sb[i] !== exp_sb[i]) begin
        n_fail++;
        $display("FAIL load cyc%0d got state=%0d strobes=%b want state=%0d strobes=%b",
                 i, obs_st[i], obs_sb[i], exp_st[i], exp_sb[i]);
      end
    end
    n_tests++;
    if (retired_cnt !== model_cnt) begin
      n_fail++;
      $display("FAIL load_retire got=%0d want=%0d", retired_cnt, model_cnt);
    end
  endtask

  task automatic test_branch();
    int rw_seen;
    rw_seen = 0;
    run_instr(32'h00208463, 0, 0, -1);
    for (int i = 0; i < ntr; i++) begin
      if (obs_sb[i][5] !== 1'b0) rw_seen++;
      n_tests++;
      if (obs_st[i] !== exp_st[i] || obs_sb[i] !== exp_sb[i]) begin
        n_fail++;
        $display("FAIL branch cyc%0d got state=%0d strobes=%b want state=%0d strobes=%b",
                 i, obs_st[i], obs_sb[i], exp_st[i], exp_sb[i]);
      end
    end
    n_tests++;
    if (rw_seen != 0 || retired_cnt !== model_cnt || state_o !== 3'd0) begin
      n_fail++;
      $display("FAIL branch_end got reg_write_cycles=%0d cnt=%0d state=%0d want 0/%0d/0",
               rw_seen, retired_cnt, state_o, model_cnt);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      run_instr(rand_legal(), $urandom_range(0, 2), $urandom_range(0, 3), -1);
      for (int i = 0; i < ntr; i++) begin
        n_tests++;
        if (obs_st[i] !== exp_st[i] || obs_sb[i] !== exp_sb[i]) begin
          n_fail++;
          $display("FAIL random t%0d cyc%0d got state=%0d strobes=%b want state=%0d strobes=%b",
                   t, i, obs_st[i], obs_sb[i], exp_st[i], exp_sb[i]);
        end
      end
      n_tests++;
      if (retired_cnt !== model_cnt || b_retired_cnt !== 4'(model_cnt)) begin
        n_fail++;
        $display("FAIL random_cnt t%0d got=%0d/%0d want=%0d/%0d", t, retired_cnt,
                 b_retired_cnt, model_cnt, 4'(model_cnt));
      end
    end
  endtask

  task automatic test_illegal();
    int pulses;
    int unsigned cnt_before;
    pulses = 0;
    cnt_before = model_cnt;
    run_instr(32'h0000007F, $urandom_range(0, 2), 0, -1);
    for (int i = 0; i < ntr; i++) begin
      if (obs_sb[i][0] === 1'b1) pulses++;
      n_tests++;
      if (obs_st[i] !== exp_st[i] || obs_sb[i] !== exp_sb[i]) begin
        n_fail++;
        $display("FAIL illegal cyc%0d got state=%0d strobes=%b want state=%0d strobes=%b",
                 i, obs_st[i], obs_sb[i], exp_st[i], exp_sb[i]);
      end
    end
    if (TRAP) begin
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        mem_ready = 1'($urandom_range(0, 1));
        instr = $urandom;
        #1;
        if (strb[0] === 1'b1) pulses++;
        n_tests++;
        if (state_o !== 3'd7 || strb !== 13'd0) begin
          n_fail++;
          $display("FAIL halt_hold k%0d got state=%0d strobes=%b want state=7 strobes=0",
                   k, state_o, strb);
        end
      end
      n_tests++;
      if (retired_cnt !== cnt_before) begin
        n_fail++;
        $display("FAIL halt_cnt got=%0d want=%0d", retired_cnt, cnt_before);
      end
    end else begin
      n_tests++;
      if (state_o !== 3'd0 || retired_cnt !== cnt_before + 1) begin
        n_fail++;
        $display("FAIL illegal_nop got state=%0d cnt=%0d want state=0 cnt=%0d",
                 state_o, retired_cnt, cnt_before + 1);
      end
    end
    n_tests++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL illegal_pulse got=%0d want=1", pulses);
    end
    do_reset();
  endtask

  task automatic test_store_abort();
    run_instr(32'h0020A003, 0, 0, -1);
    run_instr(32'h0020A023, 0, 3, 4);
    for (int i = 0; i < ntr; i++) begin
      n_tests++;
      if (obs_st[i] !== exp_st[i] || obs_sb[i] !== exp_sb[i]) begin
        n_fail++;
        $display("FAIL store_abort cyc%0d got state=%0d strobes=%b want state=%0d strobes=%b",
                 i, obs_st[i], obs_sb[i], exp_st[i], exp_sb[i]);
      end
    end
    n_tests++;
    if (state_o !== 3'd0 || retired_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL store_abort_end got state=%0d cnt=%0d want state=0 cnt=0",
               state_o, retired_cnt);
    end
    run_instr(32'h0020A023, 1, 1, -1);
    for (int i = 0; i < ntr; i++) begin
      n_tests++;
      if (obs_st[i] !== exp_st[i] || obs_sb[i] !== exp_sb[i]) begin
        n_fail++;
        $display("FAIL store_after cyc%0d got state=%0d strobes=%b want state=%0d strobes=%b",
                 i, obs_st[i], obs_sb[i], exp_st[i], exp_sb[i]);
      end
    end
    n_tests++;
    if (retired_cnt !== model_cnt) begin
      n_fail++;
      $display("FAIL store_after_cnt got=%0d want=%0d", retired_cnt, model_cnt);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int t = 0; t < 16; t++) begin
      run_instr(rand_legal(), 0, $urandom_range(0, 1), -1);
      for (int i = 0; i < ntr; i++) begin
        n_tests++;
        if (obs_st[i] !== exp_st[i] || obs_sb[i] !== exp_sb[i]) begin
          n_fail++;
          $display("FAIL wrap t%0d cyc%0d got state=%0d strobes=%b want state=%0d strobes=%b",
                   t, i, obs_st[i], obs_sb[i], exp_st[i], exp_sb[i]);
        end
      end
    end
    n_tests++;
    if (b_retired_cnt !== 4'd0 || retired_cnt !== 32'd16) begin
      n_fail++;
      $display("FAIL wrap_cnt got=%0d/%0d want=0/16", b_retired_cnt, retired_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_r_add();
    test_load();
    test_branch();
    test_random();
    test_illegal();
    test_store_abort();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
